// File: rtl/seven_seg_scan_mux.sv
// Four-digit common-anode 7-segment scanner: one shared active-low segment bus,
// per-slot anti-ghosting blank, and inputs shadowed once per frame for coherence.
module seven_seg_scan_mux #(
    parameter int REFRESH_BITS = 18,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] digit_en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       frame_tick
);

    localparam int                OFF_W     = REFRESH_BITS - 2;
    localparam logic [OFF_W-1:0]  BLANK_OFF = OFF_W'(BLANK_CYCLES);

    logic [REFRESH_BITS-1:0] q;
    logic [7:0]              shadow0, shadow1, shadow2, shadow3;

    logic [1:0]       slot_p0;
    logic [OFF_W-1:0] offset_p0;
    logic             wrap_p0;
    logic [7:0]       pat_p0;
    logic [3:0]       an_p0;
    logic [7:0]       sseg_p0;

    // Returns {an, sseg} for one slot; blanked during the slot's leading
    // guard interval or when the digit is disabled.
    function automatic logic [11:0] decode_slot(
        input logic [1:0]       slot,
        input logic [OFF_W-1:0] offset,
        input logic [3:0]       en,
        input logic [7:0]       pat
    );
        logic [3:0] an_v;
        logic [7:0] sseg_v;
        if ((offset < BLANK_OFF) || !en[slot]) begin
            an_v   = 4'b1111;
            sseg_v = 8'hFF;
        end else begin
            an_v   = ~(4'b0001 << slot);
            sseg_v = pat;
        end
        return {an_v, sseg_v};
    endfunction

    // Stage p0: combinational decode of counter position and shadows
    assign slot_p0   = q[REFRESH_BITS-1:REFRESH_BITS-2];
    assign offset_p0 = q[OFF_W-1:0];
    assign wrap_p0   = (q == '1);

    always_comb begin
        pat_p0 = shadow0;
        case (slot_p0)
            2'd0: pat_p0 = shadow0;
            2'd1: pat_p0 = shadow1;
            2'd2: pat_p0 = shadow2;
            2'd3: pat_p0 = shadow3;
            default: pat_p0 = shadow0;
        endcase
    end

    assign {an_p0, sseg_p0} = decode_slot(slot_p0, offset_p0, digit_en, pat_p0);

    // Stage p1: registered outputs, counter and frame shadows
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q          <= '0;
            shadow0    <= 8'hFF;
            shadow1    <= 8'hFF;
            shadow2    <= 8'hFF;
            shadow3    <= 8'hFF;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            q          <= q + REFRESH_BITS'(1);
            an         <= an_p0;
            sseg       <= sseg_p0;
            // Registered from q == all-ones so the pulse coincides with q == 0.
            frame_tick <= wrap_p0;
            if (wrap_p0) begin
                shadow0 <= in0;
                shadow1 <= in1;
                shadow2 <= in2;
                shadow3 <= in3;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with S = 16 and a 4-cycle blank.
module tb_seven_seg_scan_mux;

    logic       clk;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] digit_en;
    logic [3:0] an;
    logic [7:0] sseg;
    logic       frame_tick;

    int tests  = 0;
    int failed = 0;
    int n      = 0;

    seven_seg_scan_mux #(.REFRESH_BITS(6), .BLANK_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .digit_en(digit_en),
        .an(an), .sseg(sseg), .frame_tick(frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         n;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       ft;
        logic [7:0] in1_next;
        logic [3:0] en_next;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input int at, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s @n=%0d: got %h expected %h", nm, at, act, exp);
        end
    endtask

    // Advance to 'target' rising edges after release, then sample mid-cycle.
    task automatic adv_to(input int target);
        while (n < target) begin
            @(posedge clk);
            n++;
        end
        #2;
    endtask

    function automatic vec_t mk(input int nn, input logic [3:0] a, input logic [7:0] s,
                                input logic f, input logic [7:0] i1, input logic [3:0] e);
        vec_t v;
        v.n = nn; v.an = a; v.sseg = s; v.ft = f; v.in1_next = i1; v.en_next = e;
        return v;
    endfunction

    initial begin
        int pulses;
        vecs.push_back(mk(  1, 4'hF, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk(  5, 4'hE, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 63, 4'h7, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 64, 4'h7, 8'hFF, 1'b1, 8'hF9, 4'hF));
        vecs.push_back(mk( 65, 4'hF, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 68, 4'hF, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 69, 4'hE, 8'hC0, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 80, 4'hE, 8'hC0, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 81, 4'hF, 8'hFF, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk( 85, 4'hD, 8'hF9, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk(101, 4'hB, 8'hA4, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk(117, 4'h7, 8'hB0, 1'b0, 8'hF9, 4'hF));
        vecs.push_back(mk(128, 4'h7, 8'hB0, 1'b1, 8'hF9, 4'hF));
        vecs.push_back(mk(148, 4'hF, 8'hFF, 1'b0, 8'h92, 4'hF));
        vecs.push_back(mk(149, 4'hD, 8'hF9, 1'b0, 8'h92, 4'hF));
        vecs.push_back(mk(160, 4'hD, 8'hF9, 1'b0, 8'h92, 4'hF));
        vecs.push_back(mk(192, 4'h7, 8'hB0, 1'b1, 8'h92, 4'hF));
        vecs.push_back(mk(213, 4'hD, 8'h92, 1'b0, 8'h92, 4'hF));
        vecs.push_back(mk(255, 4'h7, 8'hB0, 1'b0, 8'h92, 4'hA));
        vecs.push_back(mk(256, 4'h7, 8'hB0, 1'b1, 8'h92, 4'hA));
        vecs.push_back(mk(261, 4'hF, 8'hFF, 1'b0, 8'h92, 4'hA));
        vecs.push_back(mk(277, 4'hD, 8'h92, 1'b0, 8'h92, 4'hA));
        vecs.push_back(mk(280, 4'hD, 8'h92, 1'b0, 8'h92, 4'h8));
        vecs.push_back(mk(281, 4'hF, 8'hFF, 1'b0, 8'h92, 4'h8));
        vecs.push_back(mk(293, 4'hF, 8'hFF, 1'b0, 8'h92, 4'h8));
        vecs.push_back(mk(309, 4'h7, 8'hB0, 1'b0, 8'h92, 4'hF));
        vecs.push_back(mk(330, 4'hE, 8'hC0, 1'b0, 8'h92, 4'hF));

        reset = 1'b1;
        in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
        digit_en = 4'hF;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_an", 0, 8'(an), 8'h0F);
        chk("reset_sseg", 0, sseg, 8'hFF);
        chk("reset_ft", 0, 8'(frame_tick), 8'h00);
        reset = 1'b0;
        n = 0;

        foreach (vecs[i]) begin
            adv_to(vecs[i].n);
            chk("vec_an", n, 8'(an), 8'(vecs[i].an));
            chk("vec_sseg", n, sseg, vecs[i].sseg);
            chk("vec_ft", n, 8'(frame_tick), 8'(vecs[i].ft));
            in1      = vecs[i].in1_next;
            digit_en = vecs[i].en_next;
        end

        // Asynchronous reset between edges while slot 2 is being driven
        adv_to(360);
        chk("pre_rst_an", n, 8'(an), 8'h0B);
        chk("pre_rst_sseg", n, sseg, 8'hA4);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_an", n, 8'(an), 8'h0F);
        chk("async_rst_sseg", n, sseg, 8'hFF);
        chk("async_rst_ft", n, 8'(frame_tick), 8'h00);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        n = 0;

        adv_to(1);
        chk("restart_an", n, 8'(an), 8'h0F);
        chk("restart_sseg", n, sseg, 8'hFF);
        adv_to(5);
        chk("restart_slot0_an", n, 8'(an), 8'h0E);
        chk("restart_slot0_sseg", n, sseg, 8'hFF);
        adv_to(63);
        chk("restart_ft_early", n, 8'(frame_tick), 8'h00);
        adv_to(64);
        chk("restart_ft", n, 8'(frame_tick), 8'h01);
        adv_to(69);
        chk("restart_data_an", n, 8'(an), 8'h0E);
        chk("restart_data_sseg", n, sseg, 8'hC0);

        // Five more frames: one-cycle tick every 64 cycles, never two anodes low
        pulses = 0;
        while (n < 384) begin
            adv_to(n + 1);
            if (frame_tick === 1'b1) pulses++;
            chk("ft_period", n, 8'(frame_tick), ((n % 64) == 0) ? 8'h01 : 8'h00);
            chk("an_onehot", n, 8'($countones(~an) <= 1), 8'h01);
        end
        chk("ft_pulse_count", n, 8'(pulses), 8'd5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_mux.md
# seven_seg_scan_mux

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It accepts four per-digit active-low segment patterns and scans them onto one shared segment bus with active-low anode enables. Its inputs are the `seg` bytes produced by the `hex_to_7seg` decoders, so BCD/hex results reach a multiplexed board display. Each slot starts with an anti-ghosting blank, and inputs are captured once per frame so that every frame shows a consistent value set.

## Interface
- `REFRESH_BITS`, default 18: width of the refresh counter. Slot length is S = 2^(REFRESH_BITS-2) cycles. Frame length is 4S. Minimum value is 4.
- `BLANK_CYCLES`, default 16: number of blanked cycles at the start of each slot. Must satisfy 0 ≤ BLANK_CYCLES < S.

Ports:
- `clk`, input, 1: the single clock; all state is clocked on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in0`, input, 8: digit 0 (rightmost) pattern, active-low; bit 7 = dp, bits 6:0 = g..a.
- `in1`, input, 8: digit 1 pattern, same encoding.
- `in2`, input, 8: digit 2 pattern, same encoding.
- `in3`, input, 8: digit 3 pattern, same encoding.
- `digit_en`, input, 4: per-digit enable, 1 = shown. Sampled live, not shadowed.
- `an`, output, 4: anode enables, active-low, at most one bit low.
- `sseg`, output, 8: shared segment bus, active-low.
- `frame_tick`, output, 1: one-cycle pulse marking the start of a frame.

## Operation
- Refresh counter `q` (REFRESH_BITS wide) increments every cycle and wraps from all-ones to 0.
- Slot index is `q[REFRESH_BITS-1:REFRESH_BITS-2]`. Slot offset is `q[REFRESH_BITS-3:0]`.
- Four 8-bit shadow registers capture in0..in3 on the clock edge where `q` wraps from all-ones to 0.
  - Input changes at any other time are ignored until the next wrap.
- Output decode is computed from the current `q`, the shadows and `digit_en`, then registered:
  - **Blank:** if offset < BLANK_CYCLES, or `digit_en[slot]` = 0, then an = 4'b1111 and sseg = 8'hFF.
  - **Otherwise:** `an` is all ones except bit [slot] = 0, and sseg = shadow[slot].
- `frame_tick` is registered. It is 1 for exactly the one cycle in which `q` == 0.
- The block has no other state and no state machine beyond the counter.
- On reset assertion, asynchronously and without waiting for a clock edge:
  - q = 0
  - shadows = 8'hFF
  - an = 4'b1111
  - sseg = 8'hFF
  - frame_tick = 0
- After reset deassertion, the first frame shows the reset shadows, so the display is blank. Real data appears from the second frame onward.

## Timing
- Outputs have 1-cycle latency. `an`/`sseg` in cycle t reflect the decode of `q`, shadows and `digit_en` in cycle t-1.
- Shadow-to-display latency: a value captured at the wrap edge first appears on `sseg` at offset BLANK_CYCLES of slot 0, one cycle later.
- Worst-case input-to-display latency is 4S + BLANK_CYCLES + 1 cycles.
- Within each slot the display is blank for BLANK_CYCLES cycles, then driven for S − BLANK_CYCLES cycles.
  - With BLANK_CYCLES = 0 the display is never blanked between slots.
- `frame_tick` period is exactly 4S cycles and its width is exactly 1 cycle.
- Simultaneous events:
  - An input change on the wrap edge: the value present at that edge is captured.
  - A `digit_en` change takes effect on the next registered output, with 1-cycle latency.
- Reset mid-slot: outputs blank immediately. Scanning restarts at slot 0, offset 0 on the first edge after deassertion.
- Defaults at 100 MHz: S = 65536 cycles = 655 µs per digit, about 381 Hz frame rate.

## Test plan
Use REFRESH_BITS = 6 (S = 16) and BLANK_CYCLES = 4 in simulation.

1. **Reset and first frame.** Hold reset for 3 cycles, then release with in0..in3 = C0/F9/A4/B0 and digit_en = 4'hF → during reset an = 1111, sseg = FF, frame_tick = 0. The first frame (q = 0..63) stays fully blank. frame_tick pulses at cycle 64.
2. **Scan order.** Same inputs, observe the second frame → per slot, 4 cycles blank then 12 cycles driven:
   - an = 1110 with sseg = C0
   - then an = 1101 with sseg = F9
   - then an = 1011 with sseg = A4
   - then an = 0111 with sseg = B0
   - Every transition lags q by one cycle. `an` is never low on more than one bit.
3. **Frame coherence.** Change in1 from F9 to 92 at q = 20 → the slot-1 display stays F9 for the rest of that frame. 92 appears in slot 1 of the next frame.
4. **Digit enable.** Set digit_en = 4'b1010 → slots 0 and 2 stay fully blank (an = 1111, sseg = FF). Slots 1 and 3 display normally.
5. **Asynchronous reset mid-slot.** Assert reset at q = 40 between clock edges → an = 1111 and sseg = FF before the next edge. After release, slot 0 restarts and frame_tick next pulses after 64 cycles.
6. **frame_tick period.** Run 5 frames → frame_tick is high for exactly 1 cycle every 64 cycles, coincident with q = 0.
